// File: rtl/sad_pkg.sv
// Shared definitions for the SAD accumulator: default data width, FSM state
// encoding and the sum-width helper.
package sad_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } sad_state_e;

  // Wide enough for len samples of magnitude up to 2^data_w.
  function automatic int sad_sum_w(input int data_w, input int len);
    return data_w + 1 + $clog2(len);
  endfunction

endpackage

// File: rtl/sad_abs.sv
// Converts a modulo-2^DATA_W difference plus its borrow (sign) into an
// unsigned DATA_W+1 bit magnitude.
module sad_abs
  import sad_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] diff_data,
  input  logic              diff_borrow,
  output logic [DATA_W:0]   mag
);

  // borrow=1 with diff=0 means A-B = -2^DATA_W, so the extra bit is required.
  always_comb begin
    if (diff_borrow) begin
      mag = {1'b1, {DATA_W{1'b0}}} - {1'b0, diff_data};
    end else begin
      mag = {1'b0, diff_data};
    end
  end

endmodule

// File: rtl/sad_accumulator.sv
// Accumulates BLOCK_LEN absolute differences into one SAD and offers it over
// valid/ready. Optional best-block tracking is enabled by SAD_MIN_TRACK_EN.
module sad_accumulator
  import sad_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BLOCK_LEN = 16,
  parameter int IDX_W     = 8,
  parameter int SUM_W     = sad_sum_w(DATA_W, BLOCK_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] diff_data,
  input  logic              diff_borrow,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SUM_W-1:0]  sad_sum,
  output logic [IDX_W-1:0]  blk_idx
`ifdef SAD_MIN_TRACK_EN
  ,
  output logic [SUM_W-1:0]  min_sad,
  output logic [IDX_W-1:0]  min_idx
`endif
);

  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  sad_state_e        state_q, state_d;
  logic [SUM_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [DATA_W:0]   mag;
  logic [SUM_W-1:0]  mag_ext;
  logic [SUM_W-1:0]  acc_plus;
  logic              accept;
  logic              block_done;

  sad_abs #(.DATA_W(DATA_W)) u_abs (
    .diff_data  (diff_data),
    .diff_borrow(diff_borrow),
    .mag        (mag)
  );

  assign mag_ext  = {{(SUM_W - DATA_W - 1){1'b0}}, mag};
  assign acc_plus = acc_q + mag_ext;
  assign accept   = in_valid && (state_q != DONE);

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    block_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = mag_ext;
          cnt_d   = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_LAST) begin
            sum_d      = acc_plus;
            acc_d      = '0;
            cnt_d      = '0;
            block_done = 1'b1;
            state_d    = DONE;
          end else begin
            acc_d = acc_plus;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign sad_sum   = sum_q;
  assign blk_idx   = idx_q;

`ifdef SAD_MIN_TRACK_EN
  logic [SUM_W-1:0] min_sad_q, min_sad_d;
  logic [IDX_W-1:0] min_idx_q, min_idx_d;

  // Strict less-than so a tie keeps the earlier block.
  always_comb begin
    min_sad_d = min_sad_q;
    min_idx_d = min_idx_q;
    if (block_done && (acc_plus < min_sad_q)) begin
      min_sad_d = acc_plus;
      min_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_sad_q <= '1;
      min_idx_q <= '0;
    end else begin
      min_sad_q <= min_sad_d;
      min_idx_q <= min_idx_d;
    end
  end

  assign min_sad = min_sad_q;
  assign min_idx = min_idx_q;
`endif

endmodule
